memaccess_stage: RTL

Parametrised memory-access stage of the multicycle MIPS datapath, sitting between the execute and writeback stages. It accepts one operation from execute through a valid/ready handshake: pass-through, word load or word store. It performs the operation against an internal word-addressed data memory with configurable access latency. It presents the result to writeback with a valid/ready handshake, so either neighbour can stall it.

---
 rtl/memaccess_pkg.sv | 21 ++
 rtl/memaccess_if.sv | 27 ++
 rtl/memaccess_ram.sv | 20 ++
 rtl/memaccess_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/memaccess_pkg.sv
// Shared types for the memory-access stage: operation codes and FSM states.
package memaccess_pkg;

  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HOLD
  } state_t;

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memaccess_if.sv
// Execute -> memaccess -> writeback handshake bundle; slave is the stage, master drives execute side and wb_ready.
interface memaccess_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              execute;
  logic              ex_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [REG_W-1:0]  rd_in;
  logic              memaccess;
  logic              wb_ready;
  logic [DATA_W-1:0] d;
  logic [REG_W-1:0]  rd_out;
  logic              err;

  modport master (
    output execute, op, addr, wdata, rd_in, wb_ready,
    input  ex_ready, memaccess, d, rd_out, err
  );

  modport slave (
    input  execute, op, addr, wdata, rd_in, wb_ready,
    output ex_ready, memaccess, d, rd_out, err
  );
endinterface

// File: rtl/memaccess_ram.sv
// Single-port DEPTH x DATA_W data memory: synchronous write, combinational read sampled by the stage on its access edge.
module memaccess_ram #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 256,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/memaccess_stage.sv
// MIPS memory-access stage: pass result in 1 cycle, load/store in LAT+1; stalls upstream while BUSY or while writeback holds off.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module memaccess_stage
  import memaccess_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int REG_W  = 5,
  parameter int LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  memaccess_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [REG_W-1:0]  rd_out_q, rd_out_d;
  logic              err_q, err_d;

  logic              ex_ready;
  logic              accept;
  logic              misaligned;
  logic              mem_we;
  logic [DATA_W-1:0] ram_rdata;
  op_t               in_op;
  logic              unused_addr_bits;

  assign in_op    = op_t'(bus.op);
  assign ex_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.wb_ready);
  assign accept   = bus.execute && ex_ready;

  // Bits above the word index wrap away; the low two only matter to the alignment trap.
  assign unused_addr_bits = ^{bus.addr[DATA_W-1:IDX_W+2], bus.addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (bus.addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    d_d      = d_q;
    rd_out_d = rd_out_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    case (state_q)
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_HOLD;
          if (op_q == OP_STORE) begin
            mem_we   = 1'b1;
            d_d      = '0;
            rd_out_d = '0;
          end else begin
            d_d      = ram_rdata;
            rd_out_d = rd_q;
          end
        end
      end
      S_HOLD: begin
        if (bus.wb_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // An accept in HOLD overrides the drain-to-IDLE above on the same edge.
    if (accept) begin
      op_d    = in_op;
      idx_d   = bus.addr[IDX_W+1:2];
      wdata_d = bus.wdata;
      rd_d    = bus.rd_in;
      err_d   = 1'b0;
      if (!is_mem_op(in_op)) begin
        state_d  = S_HOLD;
        d_d      = bus.addr;
        rd_out_d = bus.rd_in;
      end else if (misaligned) begin
        state_d  = S_HOLD;
        d_d      = '0;
        rd_out_d = '0;
        err_d    = 1'b1;
      end else begin
        state_d = S_BUSY;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      rd_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      rd_out_q <= rd_out_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    rd_q    <= rd_d;
  end

  // A store whose access edge meets reset is dropped.
  memaccess_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (mem_we && !rst),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  assign bus.ex_ready  = ex_ready;
  assign bus.memaccess = (state_q == S_HOLD);
  assign bus.d         = d_q;
  assign bus.rd_out    = rd_out_q;
  assign bus.err       = err_q;
endmodule
